// File: rtl/sw_mem_write.sv
// Switch-driven data-memory writer: two debounced key presses assemble a 32-bit word
// (low half first) and emit a one-cycle write at an auto-incrementing address.
module sw_mem_write #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,   // must equal 2*SW_WIDTH
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BASE_ADDR       = 0,
    parameter int ADDR_STEP       = 4,
    parameter int MAX_WORDS       = 256,
    localparam int CNT_W          = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    input  logic                  write_in,
    input  logic                  clear_in,
    input  logic [SW_WIDTH-1:0]   sw_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_mem_wr_en_out,
    output logic                  half_sel_out,
    output logic                  full_out,
    output logic [CNT_W-1:0]      word_count_out
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_LO,
        ST_HI,
        ST_WR,
        ST_FULL
    } state_t;

    // Bit 0 = write key, bit 1 = clear key; both active low.
    logic [1:0] key_raw;
    logic [1:0] key_ev;

    assign key_raw = {clear_in, write_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            ev_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            settled;

            // cnt_reg counts earlier consecutive differing samples; this one makes DEBOUNCE_CYCLES.
            assign settled = (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk_50 or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    ev_reg    <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    ev_reg    <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (settled) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        ev_reg    <= level_reg;   // only a 1->0 change is a press
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign key_ev[gi] = ev_reg;
        end
    endgenerate

    logic                  wr_ev;
    logic                  clr_ev;
    state_t                state_reg, state_next;
    logic [SW_WIDTH-1:0]   low_reg, low_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]      count_reg, count_next;

    assign wr_ev  = key_ev[0];
    assign clr_ev = key_ev[1];

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LO;
            low_reg   <= '0;
            data_reg  <= '0;
            addr_reg  <= ADDR_WIDTH'(BASE_ADDR);
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            low_reg   <= low_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        low_next   = low_reg;
        data_next  = data_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        // A clear landing on WR still lets that cycle's write through, but skips the increment.
        if (clr_ev) begin
            state_next = ST_LO;
            addr_next  = ADDR_WIDTH'(BASE_ADDR);
            count_next = '0;
        end else begin
            case (state_reg)
                ST_LO: begin
                    if (wr_ev) begin
                        low_next   = sw_in;
                        state_next = ST_HI;
                    end
                end
                ST_HI: begin
                    if (wr_ev) begin
                        data_next  = {sw_in, low_reg};
                        state_next = ST_WR;
                    end
                end
                ST_WR: begin
                    addr_next  = addr_reg + ADDR_WIDTH'(ADDR_STEP);
                    count_next = count_reg + 1'b1;
                    state_next = (count_reg == CNT_W'(MAX_WORDS - 1)) ? ST_FULL : ST_LO;
                end
                default: begin
                    state_next = ST_FULL;
                end
            endcase
        end
    end

    assign addr_out           = addr_reg;
    assign data_out           = data_reg;
    assign data_mem_wr_en_out = (state_reg == ST_WR);
    assign half_sel_out       = (state_reg == ST_HI);
    assign full_out           = (state_reg == ST_FULL);
    assign word_count_out     = count_reg;

endmodule

// File: tb/tb_sw_mem_write.sv
// Randomised bench for sw_mem_write: a word-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sw_mem_write;

    localparam int          D    = 4;
    localparam int          MAXW = 2;
    localparam int          STEP = 4;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk_50   = 1'b0;
    logic        rst_n    = 1'b0;
    logic        write_in = 1'b1;
    logic        clear_in = 1'b1;
    logic [15:0] sw_in    = 16'h0;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic        data_mem_wr_en_out;
    logic        half_sel_out;
    logic        full_out;
    logic [1:0]  word_count_out;

    sw_mem_write #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SW_WIDTH       (16),
        .DEBOUNCE_CYCLES(D),
        .BASE_ADDR      (0),
        .ADDR_STEP      (STEP),
        .MAX_WORDS      (MAXW)
    ) dut (
        .clk_50            (clk_50),
        .rst_n             (rst_n),
        .write_in          (write_in),
        .clear_in          (clear_in),
        .sw_in             (sw_in),
        .addr_out          (addr_out),
        .data_out          (data_out),
        .data_mem_wr_en_out(data_mem_wr_en_out),
        .half_sel_out      (half_sel_out),
        .full_out          (full_out),
        .word_count_out    (word_count_out)
    );

    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: word-level bookkeeping plus key acceptance by run length.
    logic [31:0] m_addr      = BASE;
    logic [31:0] m_data      = 32'h0;
    logic [15:0] m_low       = 16'h0;
    bit          m_have_low  = 1'b0;
    bit          m_pending   = 1'b0;
    int          m_count     = 0;
    bit          m_q1[2]     = '{1'b1, 1'b1};
    bit          m_q2[2]     = '{1'b1, 1'b1};
    bit          m_lvl[2]    = '{1'b1, 1'b1};
    int          m_run[2]    = '{0, 0};
    bit          m_ev[2]     = '{1'b0, 1'b0};

    always @(posedge clk_50 or negedge rst_n) begin : model_step
        bit       wc, cc, was_pending, s;
        bit [1:0] raw;
        if (!rst_n) begin
            m_addr = BASE; m_data = 32'h0; m_low = 16'h0;
            m_have_low = 0; m_pending = 0; m_count = 0;
            for (int k = 0; k < 2; k++) begin
                m_q1[k] = 1; m_q2[k] = 1; m_lvl[k] = 1; m_run[k] = 0; m_ev[k] = 0;
            end
        end else begin
            wc = m_ev[0];
            cc = m_ev[1];
            was_pending = m_pending;
            m_pending = 0;
            if (was_pending && !cc) begin
                m_addr  = m_addr + STEP;
                m_count = m_count + 1;
            end
            if (cc) begin
                m_have_low = 0;
                m_addr     = BASE;
                m_count    = 0;
            end else if (wc && !was_pending && m_count < MAXW) begin
                if (!m_have_low) begin
                    m_low = sw_in;
                    m_have_low = 1;
                end else begin
                    m_data = {sw_in, m_low};
                    m_have_low = 0;
                    m_pending = 1;
                end
            end
            raw = {clear_in, write_in};
            for (int k = 0; k < 2; k++) begin
                s = m_q2[k];
                m_q2[k] = m_q1[k];
                m_q1[k] = raw[k];
                m_ev[k] = 0;
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_ev[k]  = m_lvl[k];
                        m_lvl[k] = s;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    end

    always @(negedge clk_50) begin
        check("addr", addr_out, m_addr);
        check("data", data_out, m_data);
        check("wr_en", 32'(data_mem_wr_en_out), 32'(m_pending));
        check("half_sel", 32'(half_sel_out), 32'(m_have_low));
        check("full", 32'(full_out), 32'(m_count == MAXW));
        check("count", 32'(word_count_out), 32'(m_count));
    end

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          half_rises = 0;
    logic        half_prev  = 1'b0;

    always @(negedge clk_50) begin
        if (data_mem_wr_en_out === 1'b1) begin
            log_addr.push_back(addr_out);
            log_data.push_back(data_out);
            $display("write addr=%h data=%h at %0t", addr_out, data_out, $time);
        end
        if (half_sel_out === 1'b1 && half_prev === 1'b0) half_rises++;
        half_prev = half_sel_out;
    end

    function automatic logic [31:0] last_addr();
        return (log_addr.size() == 0) ? 32'hxxxxxxxx : log_addr[log_addr.size()-1];
    endfunction

    function automatic logic [31:0] last_data();
        return (log_data.size() == 0) ? 32'hxxxxxxxx : log_data[log_data.size()-1];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic press_write(input logic [15:0] v);
        sw_in = v;
        write_in = 1'b0;
        tick(D + 8);
        write_in = 1'b1;
        tick(D + 8);
    endtask

    task automatic press_clear();
        clear_in = 1'b0;
        tick(D + 8);
        clear_in = 1'b1;
        tick(D + 8);
    endtask

    task automatic pulse_reset();
        @(posedge clk_50);
        #2 rst_n = 1'b0;
        @(posedge clk_50);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, addr_out, 32'h0);
        check({tag, "_data"}, data_out, 32'h0);
        check({tag, "_wr"}, 32'(data_mem_wr_en_out), 32'h0);
        check({tag, "_half"}, 32'(half_sel_out), 32'h0);
        check({tag, "_full"}, 32'(full_out), 32'h0);
        check({tag, "_count"}, 32'(word_count_out), 32'h0);
    endtask

    int n0;
    int nlog;

    initial begin
        tick(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick(2);

        // Basic two-press word
        press_write(16'h1234);
        check("lo_half_sel", 32'(half_sel_out), 32'h1);
        press_write(16'hABCD);
        check("w1_nwr", 32'(log_addr.size()), 32'd1);
        check("w1_addr", last_addr(), 32'h0);
        check("w1_data", last_data(), 32'hABCD1234);
        check("w1_model", m_data, 32'hABCD1234);
        check("w1_ptr", addr_out, 32'h4);
        check("w1_cnt", 32'(word_count_out), 32'd1);

        // Bouncing key then a long hold gives one event
        n0 = half_rises;
        sw_in = 16'h5678;
        for (int i = 0; i < 10; i++) begin
            write_in = ~write_in;
            tick(2);
        end
        write_in = 1'b0;
        tick(100);
        write_in = 1'b1;
        tick(D + 8);
        check("bounce_rises", 32'(half_rises - n0), 32'd1);
        check("bounce_nwr", 32'(log_addr.size()), 32'd1);

        // Fill up, then presses are ignored, then clear
        press_write(16'h9ABC);
        check("w2_addr", last_addr(), 32'h4);
        check("w2_data", last_data(), 32'h9ABC5678);
        check("full_flag", 32'(full_out), 32'h1);
        check("full_ptr", addr_out, 32'h8);
        press_write(16'h1111);
        press_write(16'h2222);
        check("full_nwr", 32'(log_addr.size()), 32'd2);
        check("full_ptr2", addr_out, 32'h8);
        press_clear();
        check("clr_ptr", addr_out, 32'h0);
        check("clr_cnt", 32'(word_count_out), 32'd0);
        check("clr_full", 32'(full_out), 32'h0);
        check("clr_data", data_out, 32'h9ABC5678);

        // Clear and write together while in HI
        press_write(16'h1111);
        sw_in = 16'h2222;
        write_in = 1'b0;
        clear_in = 1'b0;
        tick(D + 8);
        write_in = 1'b1;
        clear_in = 1'b1;
        tick(D + 8);
        check("cw_half", 32'(half_sel_out), 32'h0);
        check("cw_nwr", 32'(log_addr.size()), 32'd2);
        check("cw_ptr", addr_out, 32'h0);

        // Clear coincident with the write cycle
        press_write(16'h3333);
        press_write(16'h4444);
        press_write(16'h5555);
        nlog = log_addr.size();
        sw_in = 16'h6666;
        write_in = 1'b0;
        tick(1);
        clear_in = 1'b0;
        tick(D + 8);
        write_in = 1'b1;
        clear_in = 1'b1;
        tick(D + 8);
        check("cwr_nwr", 32'(log_addr.size() - nlog), 32'd1);
        check("cwr_addr", last_addr(), 32'h4);
        check("cwr_data", last_data(), 32'h66665555);
        check("cwr_ptr", addr_out, 32'h0);
        check("cwr_cnt", 32'(word_count_out), 32'd0);

        // Reset while holding a low half
        press_write(16'h0F0F);
        pulse_reset();
        check_reset_values("midrst");
        press_write(16'h7777);
        press_write(16'h8888);
        check("rst_addr", last_addr(), 32'h0);
        check("rst_data", last_data(), 32'h88887777);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                write_in = 1'b0;
                tick(1);
                write_in = 1'b1;
                tick(2);
            end
            if (r < 7) begin
                sw_in = 16'($urandom);
                write_in = 1'b0;
                tick(D + 4 + $urandom_range(0, 10));
                write_in = 1'b1;
            end else if (r < 9) begin
                clear_in = 1'b0;
                tick(D + 4 + $urandom_range(0, 10));
                clear_in = 1'b1;
            end else begin
                sw_in = 16'($urandom);
                write_in = 1'b0;
                clear_in = 1'b0;
                tick(D + 6);
                write_in = 1'b1;
                clear_in = 1'b1;
            end
            tick(D + 5 + $urandom_range(0, 6));
        end
        tick(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sw_mem_write.md
# sw_mem_write

Board-driven data-memory writer: operator sets a 16-bit value on the switches and presses a key twice, low half then high half. The block assembles a 32-bit word and issues a single-cycle write into data memory at an auto-incrementing address. It is the write-side counterpart of the LCD memory reader and drives the data memory write port (address, data, write enable) during board bring-up, when the core is held idle.

## Interface
- ADDR_WIDTH, 32, width of addr_out
- DATA_WIDTH, 32, width of data_out; must equal 2*SW_WIDTH
- SW_WIDTH, 16, switch bus width
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a key level (20 ms at 50 MHz)
- BASE_ADDR, 0, first write address and post-clear address
- ADDR_STEP, 4, address increment per written word
- MAX_WORDS, 256, words accepted before the block reports full
- clk_50  input  1  board clock, 50 MHz, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- write_in  input  1  raw key, active low (pressed = 0)
- clear_in  input  1  raw key, active low; rewinds pointer
- sw_in  input  SW_WIDTH  raw switch value, sampled on accepted press
- addr_out  output  ADDR_WIDTH  current write pointer
- data_out  output  DATA_WIDTH  last assembled word
- data_mem_wr_en_out  output  1  data memory write enable, one-cycle pulse
- half_sel_out  output  1  0 = expecting low half, 1 = expecting high half
- full_out  output  1  MAX_WORDS written; further writes ignored
- word_count_out  output  $clog2(MAX_WORDS+1)  words written since reset/clear

## Operation
- Key conditioning, per key: 2-FF synchronizer, then debouncer. Accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Accepted level resets to 1.
- Press event = one-cycle pulse on accepted level 1->0. Release produces no event; holding a key yields exactly one event.
- FSM states: LO, HI, WR, FULL. Reset state LO.
- LO: write event -> latch sw_in into low-half register, go HI.
- HI: write event -> data_out <= {sw_in, low half}, go WR.
- WR: data_mem_wr_en_out = 1 (Moore, registered), addr_out = pointer. Next cycle: pointer += ADDR_STEP (mod 2^ADDR_WIDTH), count += 1; go FULL if the new count == MAX_WORDS, else LO.
- FULL: write events ignored; full_out = 1.
- Clear event, any state: next state LO, pointer = BASE_ADDR, count = 0, full_out = 0; data_out keeps its value.
- Clear has priority over a simultaneous write event; the write event is discarded.
- Clear event during WR: the write pulse in that cycle still occurs at the old pointer. The post-write increment is suppressed; pointer becomes BASE_ADDR.
- half_sel_out = 1 only in HI. Write enable is never asserted outside WR.

## Timing
- Reset values: addr_out = BASE_ADDR, data_out = 0, data_mem_wr_en_out = 0, half_sel_out = 0, full_out = 0, word_count_out = 0. Low-half register = 0. Debounced levels = 1.
- Raw key edge to press event: 2 synchronizer cycles + DEBOUNCE_CYCLES, with the input stable throughout.
- Press event in cycle E:
  - LO: half_sel_out = 1 from E+1.
  - HI: data_out valid and state WR at E+1; data_mem_wr_en_out high in E+1 only.
  - E+2: addr_out and word_count_out updated; half_sel_out = 0.
- addr_out and data_out are stable throughout the WR cycle, so memory captures them on the clock edge ending WR.
- No busy handshake: the memory accepts a write every cycle. Events arrive no faster than every DEBOUNCE_CYCLES, so WR never overlaps a following event.
- rst_n assertion mid-sequence, including during WR, returns all state to reset values immediately. A pending low half is lost.

## Test plan
- DEBOUNCE_CYCLES = 4. sw_in = 16'h1234, press write_in; sw_in = 16'hABCD, press again -> exactly one wr_en pulse with addr_out = 0, data_out = 32'hABCD1234; then addr_out = 4, word_count_out = 1.
- write_in toggles every 2 cycles for 20 cycles, then holds low -> exactly one press event; half_sel_out 0->1 once. Holding 100 cycles produces no further event.
- MAX_WORDS = 2: write 2 words -> full_out = 1, addr_out = 8. Two more presses -> no wr_en, no change. Press clear_in -> addr_out = 0, count 0, full_out 0.
- Clear and write events in the same cycle while in HI -> state LO, no write pulse, addr_out = BASE_ADDR.
- Clear event coincident with WR -> wr_en pulse at the old address; next cycle addr_out = BASE_ADDR, word_count_out = 0.
- rst_n low for 1 cycle while in HI -> all outputs at reset values. A subsequent pair of presses writes a fresh word to BASE_ADDR.
